sprime_block_fetch: RTL and testbench
=====================================

Name: sprime_block_fetch

Overview:
- Upstream feeder of the MIC17 decoder's IDCT stage.
- On Start, it reads one 8x8 block of pre-IDCT coefficients (S') for one plane from external SRAM. It writes the 64 samples, sign-extended, into the S'-block dual-port RAM through one write port.
- It pulses Finish when the block is fully resident, so the IDCT stage can begin.

Parameters:
- SPRIME_BASE, 76800: SRAM word address of Y-plane S' coefficient (0,0).
- Y_WIDTH, 320: Y-plane coefficients per row.
- UV_WIDTH, 160: U/V-plane coefficients per row.
- HEIGHT, 240: rows per plane.

Ports:
- Clock  in  1  system clock; all state updates on its rising edge.
- Resetn  in  1  asynchronous active-low reset.
- Start  in  1  one-cycle request; sampled only in IDLE.
- Plane  in  2  0=Y, 1=U, 2=V; 3 is illegal.
- Block_col  in  6  block column; Y: 0..39, U/V: 0..19.
- Block_row  in  5  block row; 0..29.
- Finish  out  1  one-cycle pulse: block written.
- Busy  out  1  high from the accepted Start until Finish, inclusive.
- SRAM_address  out  18  registered read address.
- SRAM_read_data  in  16  SRAM data; 2-cycle latency.
- SRAM_we_n  out  1  constant 1; this block never writes SRAM.
- Dpram_address  out  7  write address, 0..63.
- Dpram_write_data  out  32  sign-extended coefficient.
- Dpram_we  out  1  write enable.

Behaviour:
- Reset values (asynchronous, also mid-operation): state=IDLE, Finish=0, Busy=0, SRAM_address=0, Dpram_address=0, Dpram_write_data=0, Dpram_we=0; all counters cleared.
- SRAM_we_n is tied to 1 at all times.
- Plane offsets:
  - Y = SPRIME_BASE
  - U = SPRIME_BASE + Y_WIDTH*HEIGHT (153600)
  - V = U + UV_WIDTH*HEIGHT (192000)
- Address for sample (r,c), r,c in 0..7: offset + (Block_row*8 + r)*W + Block_col*8 + c, where W is Y_WIDTH or UV_WIDTH by plane. Compute in at least 18 bits; there is no overflow for legal inputs.
- Plane, Block_col and Block_row are latched on the accepted Start; later changes have no effect on the block in flight.
- Start acceptance: Start=1 in IDLE with legal inputs. Illegal inputs (Plane=3, Block_col beyond 39 for Y or 19 for U/V, Block_row>29) cause Start to be ignored: remain IDLE, no Finish.
- Start while Busy is ignored.
- Read order is row-major: r outer, c inner; index k = r*8 + c.
- SRAM read latency: address driven in cycle n is captured from SRAM_read_data at the edge ending cycle n+2.
- States:
  - IDLE -> LEAD_IN on accepted Start.
  - LEAD_IN, 2 cycles: issue addresses k=0,1.
  - STREAM, 62 cycles: issue address k+2 and write sample k.
  - LEAD_OUT, 2 cycles: write samples 62,63; no new address.
  - DONE, 1 cycle: Finish=1 -> IDLE.
- Cycle-level timing, with cycle 0 ending at the accepting edge:
  - Cycles 1..64: SRAM_address takes sample addresses 0..63 on consecutive cycles.
  - Cycles 3..66: Dpram_we=1, Dpram_address=k, k=0..63.
  - Cycle 67: Finish=1.
  - Busy=1 for cycles 1..67.
  - Throughput is one sample per cycle with no bubbles.
- Dpram_write_data = {16 copies of data[15], data[15:0]}.
- Dpram_we=0 and Dpram_address holds its last value outside the write window.
- SRAM_address holds its last value after cycle 64.
- Back-to-back operation: a Start in the cycle after Finish (IDLE) is accepted; the minimum request period is 68 cycles.

Test Plan:
1. Plane=0, col=0, row=0, SRAM[76800+r*320+c] = r*8+c -> Dpram addresses 0..63 written with 0..63 on cycles 3..66; Finish at cycle 67; Busy=1 for cycles 1..67.
2. Plane=2, col=19, row=29, SRAM holds 0x8000+k -> first address 192000+232*160+152=229272, last 229272+7*160+7=230399; written data 0xFFFF8000+k (sign extension checked).
3. Plane=1, col=5, row=3 with Start pulsed again at cycle 20 and inputs changed mid-block -> second Start ignored; all addresses use U offset 153600, row 3, col 5; exactly one Finish.
4. Plane=3, or Plane=1 with col=20 -> no SRAM address change, Dpram_we never 1, Finish never 1, Busy stays 0.
5. Resetn asserted at cycle 30 of a Y block -> outputs take reset values immediately (asynchronous); after release, a fresh Start completes a full 64-sample block correctly.
6. Two back-to-back Starts (second in the cycle after Finish), Y (col 39, row 0) then U (col 0, row 0) -> 128 writes with no interleaving; Finish pulses at cycles 67 and 135.

Source files
------------

// File: rtl/sprime_block_fetch_if.sv
// Bus bundle between the S' block fetcher and its surroundings: request/response
// handshake, SRAM read port and the S'-block DPRAM write port.
interface sprime_block_fetch_if;
   logic        Start;
   logic [1:0]  Plane;
   logic [5:0]  Block_col;
   logic [4:0]  Block_row;
   logic        Finish;
   logic        Busy;
   logic [17:0] SRAM_address;
   logic [15:0] SRAM_read_data;
   logic        SRAM_we_n;
   logic [6:0]  Dpram_address;
   logic [31:0] Dpram_write_data;
   logic        Dpram_we;

   modport master (
      input  Start, Plane, Block_col, Block_row, SRAM_read_data,
      output Finish, Busy, SRAM_address, SRAM_we_n,
             Dpram_address, Dpram_write_data, Dpram_we
   );

   modport slave (
      output Start, Plane, Block_col, Block_row, SRAM_read_data,
      input  Finish, Busy, SRAM_address, SRAM_we_n,
             Dpram_address, Dpram_write_data, Dpram_we
   );
endinterface

// File: rtl/sprime_block_fetch.sv
// Fetches one 8x8 block of S' coefficients from SRAM and streams the 64 samples,
// sign-extended, into the S'-block DPRAM at one sample per cycle.
module sprime_block_fetch #(
   parameter int SPRIME_BASE = 76800,
   parameter int Y_WIDTH     = 320,
   parameter int UV_WIDTH    = 160,
   parameter int HEIGHT      = 240
) (
   input  logic Clock,
   input  logic Resetn,
   sprime_block_fetch_if.master bus
);

   localparam logic [17:0] Y_OFFSET = 18'(SPRIME_BASE);
   localparam logic [17:0] U_OFFSET = 18'(SPRIME_BASE + Y_WIDTH * HEIGHT);
   localparam logic [17:0] V_OFFSET = 18'(SPRIME_BASE + Y_WIDTH * HEIGHT + UV_WIDTH * HEIGHT);
   localparam logic [5:0]  Y_COLS   = 6'(Y_WIDTH / 8);
   localparam logic [5:0]  UV_COLS  = 6'(UV_WIDTH / 8);
   localparam logic [4:0]  ROWS     = 5'(HEIGHT / 8);

   typedef enum logic [2:0] {IDLE, LEAD_IN, STREAM, LEAD_OUT, DONE} state_t;

   state_t      state, state_next;
   logic [5:0]  phase_cnt;
   logic [5:0]  issue_idx;
   logic [5:0]  next_idx;
   logic [17:0] base_reg;
   logic [17:0] width_reg;
   logic [17:0] sram_addr;
   logic [17:0] next_addr;
   logic [6:0]  dp_addr;
   logic [17:0] start_base;
   logic [17:0] start_width;
   logic [17:0] start_offset;
   logic        start_legal;
   logic        accept;
   logic        busy;
   logic        finish;
   logic        dpram_we;

   // Decode the requested block's top-left address straight from the request inputs
   always_comb begin
      start_width  = 18'(UV_WIDTH);
      start_offset = U_OFFSET;
      start_legal  = 1'b0;
      case (bus.Plane)
         2'd0: begin
            start_width  = 18'(Y_WIDTH);
            start_offset = Y_OFFSET;
            start_legal  = bus.Block_col < Y_COLS;
         end
         2'd1: start_legal = bus.Block_col < UV_COLS;
         2'd2: begin
            start_offset = V_OFFSET;
            start_legal  = bus.Block_col < UV_COLS;
         end
         default: start_legal = 1'b0;
      endcase
      start_legal = start_legal && (bus.Block_row < ROWS);
      start_base  = start_offset + 18'({bus.Block_row, 3'b000}) * start_width
                    + 18'({bus.Block_col, 3'b000});
   end

   assign accept    = (state == IDLE) && bus.Start && start_legal;
   assign next_idx  = issue_idx + 6'd1;
   assign next_addr = base_reg + 18'(next_idx[5:3]) * width_reg + 18'(next_idx[2:0]);

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state     <= IDLE;
         phase_cnt <= 6'd0;
      end else begin
         state     <= state_next;
         phase_cnt <= (state_next != state) ? 6'd0 : phase_cnt + 6'd1;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:     if (accept) state_next = LEAD_IN;
         LEAD_IN:  if (phase_cnt == 6'd1) state_next = STREAM;
         STREAM:   if (phase_cnt == 6'd61) state_next = LEAD_OUT;
         LEAD_OUT: if (phase_cnt == 6'd1) state_next = DONE;
         DONE:     state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   always_comb begin
      busy     = (state != IDLE);
      finish   = (state == DONE);
      dpram_we = (state == STREAM) || (state == LEAD_OUT);
   end

   // Address issue runs two samples ahead of the write index to cover SRAM latency
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         base_reg  <= 18'd0;
         width_reg <= 18'd0;
         issue_idx <= 6'd0;
         sram_addr <= 18'd0;
         dp_addr   <= 7'd0;
      end else begin
         if (accept) begin
            base_reg  <= start_base;
            width_reg <= start_width;
            issue_idx <= 6'd0;
            sram_addr <= start_base;
         end else if ((state == LEAD_IN) || ((state == STREAM) && (issue_idx != 6'd63))) begin
            issue_idx <= next_idx;
            sram_addr <= next_addr;
         end
         if ((state == LEAD_IN) && (phase_cnt == 6'd1)) begin
            dp_addr <= 7'd0;
         end else if ((state == STREAM) || ((state == LEAD_OUT) && (phase_cnt == 6'd0))) begin
            dp_addr <= dp_addr + 7'd1;
         end
      end
   end

   assign bus.Finish           = finish;
   assign bus.Busy             = busy;
   assign bus.SRAM_address     = sram_addr;
   assign bus.SRAM_we_n        = 1'b1;
   assign bus.Dpram_address    = dp_addr;
   assign bus.Dpram_we         = dpram_we;
   assign bus.Dpram_write_data = dpram_we ? {{16{bus.SRAM_read_data[15]}}, bus.SRAM_read_data}
                                          : 32'd0;

endmodule

// File: tb/tb_sprime_block_fetch.sv
// Directed bench for sprime_block_fetch: table of block requests plus hand-built
// sequences for mid-block restart, asynchronous reset and back-to-back blocks.
module tb_sprime_block_fetch;

   typedef struct {
      logic [1:0]  plane;
      logic [5:0]  col;
      logic [4:0]  row;
      logic        accept;
      int          first_addr;
      int          width;
      logic [15:0] pattern;
   } vec_t;

   logic Clock;
   logic Resetn;
   int   n_compared;
   int   n_failed;
   int   cur_cyc;
   logic [31:0] last_sram;
   logic [31:0] last_dp;
   logic [15:0] sram [0:262143];
   logic [15:0] sram_pipe;
   vec_t vecs [0:6];
   vec_t v3, vb1, vb2;

   sprime_block_fetch_if bus ();

   sprime_block_fetch dut (
      .Clock  (Clock),
      .Resetn (Resetn),
      .bus    (bus)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Two-cycle SRAM read pipeline
   always_ff @(posedge Clock) begin
      sram_pipe          <= sram[bus.SRAM_address];
      bus.SRAM_read_data <= sram_pipe;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_failed++;
         $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cur_cyc, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic start, input logic [1:0] plane,
                                input logic [5:0] col, input logic [4:0] row);
      bus.Start     = start;
      bus.Plane     = plane;
      bus.Block_col = col;
      bus.Block_row = row;
   endtask

   function automatic logic [31:0] expAddr(input vec_t v, input int k);
      return 32'(v.first_addr + (k / 8) * v.width + (k % 8));
   endfunction

   task automatic runBlock(input vec_t v, input int last_cyc, input int restart_at,
                           input int abort_at);
      int writes;
      logic [15:0] d;
      logic aborted;
      writes  = 0;
      aborted = 1'b0;
      if (v.accept)
         for (int k = 0; k < 64; k++) sram[18'(expAddr(v, k))] = v.pattern + 16'(k);
      @(negedge Clock);
      applyStimulus(1'b1, v.plane, v.col, v.row);
      for (int cyc = 1; cyc <= last_cyc && !aborted; cyc++) begin
         @(negedge Clock);
         cur_cyc = cyc;
         if (cyc == 1) applyStimulus(1'b0, v.plane, v.col, v.row);
         if (restart_at != 0 && cyc == restart_at) applyStimulus(1'b1, 2'd0, 6'd1, 5'd1);
         if (restart_at != 0 && cyc == restart_at + 1) applyStimulus(1'b0, 2'd0, 6'd1, 5'd1);
         if (cyc == abort_at) begin
            Resetn = 1'b0;
            #1;
            checkOutput("rst_busy", 32'(bus.Busy), 32'd0);
            checkOutput("rst_finish", 32'(bus.Finish), 32'd0);
            checkOutput("rst_sram_addr", 32'(bus.SRAM_address), 32'd0);
            checkOutput("rst_dp_addr", 32'(bus.Dpram_address), 32'd0);
            checkOutput("rst_dp_we", 32'(bus.Dpram_we), 32'd0);
            checkOutput("rst_dp_data", bus.Dpram_write_data, 32'd0);
            last_sram = 32'd0;
            last_dp   = 32'd0;
            aborted   = 1'b1;
         end else begin
            checkOutput("we_n", 32'(bus.SRAM_we_n), 32'd1);
            if (bus.Dpram_we) writes++;
            if (!v.accept) begin
               checkOutput("idle_sram_addr", 32'(bus.SRAM_address), last_sram);
               checkOutput("idle_dp_we", 32'(bus.Dpram_we), 32'd0);
               checkOutput("idle_finish", 32'(bus.Finish), 32'd0);
               checkOutput("idle_busy", 32'(bus.Busy), 32'd0);
            end else begin
               checkOutput("busy", 32'(bus.Busy), 32'(cyc <= 67));
               checkOutput("finish", 32'(bus.Finish), 32'(cyc == 67));
               checkOutput("sram_addr", 32'(bus.SRAM_address),
                           expAddr(v, (cyc <= 64) ? cyc - 1 : 63));
               if (cyc >= 3 && cyc <= 66) begin
                  d = v.pattern + 16'(cyc - 3);
                  checkOutput("dp_we", 32'(bus.Dpram_we), 32'd1);
                  checkOutput("dp_addr", 32'(bus.Dpram_address), 32'(cyc - 3));
                  checkOutput("dp_data", bus.Dpram_write_data, {{16{d[15]}}, d});
               end else begin
                  checkOutput("dp_we_off", 32'(bus.Dpram_we), 32'd0);
                  checkOutput("dp_addr_hold", 32'(bus.Dpram_address),
                              (cyc < 3) ? last_dp : 32'd63);
               end
            end
         end
      end
      if (!aborted) begin
         checkOutput("write_count", 32'(writes), v.accept ? 32'd64 : 32'd0);
         if (v.accept) begin
            last_sram = expAddr(v, 63);
            last_dp   = 32'd63;
         end
      end
   endtask

   initial begin
      n_compared = 0;
      n_failed   = 0;
      cur_cyc    = 0;
      last_sram  = 32'd0;
      last_dp    = 32'd0;
      sram_pipe  = 16'd0;
      for (int i = 0; i < 262144; i++) sram[i] = 16'd0;

      vecs[0] = '{2'd0, 6'd0,  5'd0,  1'b1, 76800,  320, 16'h0000};
      vecs[1] = '{2'd2, 6'd19, 5'd29, 1'b1, 229272, 160, 16'h8000};
      vecs[2] = '{2'd3, 6'd0,  5'd0,  1'b0, 0,      0,   16'h0000};
      vecs[3] = '{2'd1, 6'd20, 5'd0,  1'b0, 0,      0,   16'h0000};
      vecs[4] = '{2'd0, 6'd40, 5'd0,  1'b0, 0,      0,   16'h0000};
      vecs[5] = '{2'd0, 6'd0,  5'd30, 1'b0, 0,      0,   16'h0000};
      vecs[6] = '{2'd0, 6'd39, 5'd29, 1'b1, 151352, 320, 16'hFFC0};
      v3      = '{2'd1, 6'd5,  5'd3,  1'b1, 157480, 160, 16'h7FC0};
      vb1     = '{2'd0, 6'd39, 5'd0,  1'b1, 77112,  320, 16'h0100};
      vb2     = '{2'd1, 6'd0,  5'd0,  1'b1, 153600, 160, 16'hF000};

      Resetn = 1'b0;
      applyStimulus(1'b0, 2'd0, 6'd0, 5'd0);
      repeat (3) @(negedge Clock);
      checkOutput("reset_busy", 32'(bus.Busy), 32'd0);
      checkOutput("reset_finish", 32'(bus.Finish), 32'd0);
      checkOutput("reset_sram_addr", 32'(bus.SRAM_address), 32'd0);
      checkOutput("reset_dp_we", 32'(bus.Dpram_we), 32'd0);
      checkOutput("reset_we_n", 32'(bus.SRAM_we_n), 32'd1);
      Resetn = 1'b1;

      for (int i = 0; i < 7; i++) begin
         $display("[TB] vector %0d plane=%0d col=%0d row=%0d", i, vecs[i].plane, vecs[i].col, vecs[i].row);
         runBlock(vecs[i], 69, 0, 0);
      end

      $display("[TB] restart ignored while busy");
      runBlock(v3, 69, 20, 0);

      $display("[TB] asynchronous reset mid-block");
      runBlock(vecs[0], 69, 0, 30);
      repeat (2) @(negedge Clock);
      Resetn = 1'b1;
      runBlock(vecs[0], 69, 0, 0);

      $display("[TB] back-to-back blocks");
      runBlock(vb1, 67, 0, 0);
      runBlock(vb2, 69, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
      $finish;
   end

endmodule
